// File: rtl/mem_arbiter.sv
// Byte-serial arbiter that shares the RAM/IO bus between icache line fills and the LSB.
// Multi-byte accesses are little-endian; IO stores stall while the UART buffer is full.
module mem_arbiter #(
    parameter logic [1:0] IO_SEL = 2'b11,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              ic_valid,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [31:0]       ic_data,
    input  logic              lsb_valid,
    input  logic              lsb_wr,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    input  logic [2:0]        lsb_len,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic              rollback
);

    typedef enum logic [1:0] {IDLE, IC_RD, LSB_RD, LSB_WR} state_t;

    state_t            r_state;
    logic              r_last_lsb;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;
    logic              r_mem_wr;
    logic              r_ic_done;
    logic [31:0]       r_ic_data;
    logic              r_lsb_done;
    logic [31:0]       r_lsb_rdata;
    logic              r_rdy_d;
    logic [7:0]        r_din_hold;

    logic              w_ic_req;
    logic              w_lsb_req;
    logic              w_grant_ic;
    logic              w_grant_lsb;
    logic              w_stall;
    logic [2:0]        w_cnt_nx;
    logic [1:0]        w_rd_idx;
    logic [7:0]        w_din;
    logic [31:0]       w_rd_word;
    logic [ADDR_W-1:0] w_addr_nx;

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = b;
        return res;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    // A requester whose done pulse is still showing has already been served.
    assign w_ic_req    = ic_valid  & ~r_ic_done;
    assign w_lsb_req   = lsb_valid & ~r_lsb_done;
    assign w_grant_ic  = w_ic_req & (~w_lsb_req | r_last_lsb);
    assign w_grant_lsb = w_lsb_req & ~w_grant_ic;

    assign w_stall   = (r_state == LSB_WR) && (r_addr[17:16] == IO_SEL) && io_buffer_full;
    assign w_cnt_nx  = r_cnt + 3'd1;
    assign w_addr_nx = r_addr + ADDR_W'(w_cnt_nx);
    assign w_rd_idx  = r_cnt[1:0] - 2'd1;

    // After an rdy pause mem_din reflects the held address, so replay the byte seen when it fell.
    assign w_din     = r_rdy_d ? mem_din : r_din_hold;
    assign w_rd_word = put_byte(r_buf, w_rd_idx, w_din);

    assign mem_a     = w_stall ? '0 : r_mem_a;
    assign mem_wr    = r_mem_wr & rdy & ~w_stall;
    assign mem_dout  = r_mem_dout;
    assign ic_done   = r_ic_done;
    assign ic_data   = r_ic_data;
    assign lsb_done  = r_lsb_done;
    assign lsb_rdata = r_lsb_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy_d <= 1'b1;
        end else begin
            r_rdy_d <= rdy;
        end
        if (r_rdy_d && !rdy) begin
            r_din_hold <= mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_lsb  <= 1'b1;
            r_cnt       <= '0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
            r_ic_done   <= 1'b0;
            r_ic_data   <= '0;
            r_lsb_done  <= 1'b0;
            r_lsb_rdata <= '0;
        end else if (rdy) begin
            r_ic_done  <= 1'b0;
            r_lsb_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!rollback && (w_grant_ic || w_grant_lsb)) begin
                        r_cnt <= '0;
                        r_buf <= '0;
                        if (w_grant_ic) begin
                            r_state    <= IC_RD;
                            r_last_lsb <= 1'b0;
                            r_len      <= 3'd4;
                            r_addr     <= ic_addr;
                            r_mem_a    <= ic_addr;
                        end else begin
                            r_state    <= lsb_wr ? LSB_WR : LSB_RD;
                            r_last_lsb <= 1'b1;
                            r_len      <= lsb_len;
                            r_addr     <= lsb_addr;
                            r_wdata    <= lsb_wdata;
                            r_mem_a    <= lsb_addr;
                            r_mem_wr   <= lsb_wr;
                            r_mem_dout <= lsb_wdata[7:0];
                        end
                    end
                end
                IC_RD, LSB_RD: begin
                    if (rollback) begin
                        r_state <= IDLE;
                        r_mem_a <= '0;
                    end else begin
                        // Byte cnt-1 arrives now, one cycle behind its address.
                        if (r_cnt != 3'd0) begin
                            r_buf <= w_rd_word;
                        end
                        if (r_cnt == r_len) begin
                            r_state <= IDLE;
                            r_mem_a <= '0;
                            if (r_state == IC_RD) begin
                                r_ic_done <= 1'b1;
                                r_ic_data <= w_rd_word;
                            end else begin
                                r_lsb_done  <= 1'b1;
                                r_lsb_rdata <= w_rd_word;
                            end
                        end else begin
                            r_cnt   <= w_cnt_nx;
                            r_mem_a <= (w_cnt_nx < r_len) ? w_addr_nx : '0;
                        end
                    end
                end
                LSB_WR: begin
                    // Stores are already committed, so rollback does not cut them short.
                    if (!w_stall) begin
                        if (w_cnt_nx == r_len) begin
                            r_state    <= IDLE;
                            r_mem_wr   <= 1'b0;
                            r_mem_a    <= '0;
                            r_lsb_done <= 1'b1;
                        end else begin
                            r_cnt      <= w_cnt_nx;
                            r_mem_a    <= w_addr_nx;
                            r_mem_dout <= get_byte(r_wdata, w_cnt_nx[1:0]);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte RAM answers reads one cycle late, and
// expected bus writes and completions are queued as stimulus is applied.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        ic_valid;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_data;
    logic        lsb_valid;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic [2:0]  lsb_len;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic        rollback;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        bit          is_lsb;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    wr_t         q_wr[$];
    logic [31:0] q_ic[$];
    ev_t         q_ev[$];

    logic [7:0] ram [logic [31:0]];

    mem_arbiter #(.IO_SEL(2'b11), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .lsb_valid(lsb_valid), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_len(lsb_len), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .rollback(rollback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    // RAM returns the byte addressed in the previous cycle.
    always @(posedge clk) mem_din <= rd(mem_a);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        ic_valid = 1'b0; ic_addr = '0; lsb_valid = 1'b0; lsb_wr = 1'b0;
        lsb_addr = '0; lsb_wdata = '0; lsb_len = 3'd1;
        cyc(); cyc(); smp();
        checks++;
        if ({mem_a, mem_dout, mem_wr, ic_done, lsb_done} !== '0) begin
            errors++;
            $display("FAIL reset_bus: mem_a=%h dout=%h wr=%b ic_done=%b lsb_done=%b, required all 0",
                     mem_a, mem_dout, mem_wr, ic_done, lsb_done);
        end
        checks++;
        if (ic_data !== 32'h0 || lsb_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: ic_data=%h lsb_rdata=%h, required 0", ic_data, lsb_rdata);
        end
        cyc(); rst = 1'b0; smp();
    endtask

    task automatic test_ic_read();
        int ndone = 0;
        logic [31:0] exp;
        cyc(); ic_valid = 1'b1; ic_addr = 32'h100; q_ic.push_back(32'h0000_0513); smp();
        for (int k = 1; k <= 8; k++) begin
            cyc(); smp();
            if (k <= 4) begin
                checks++;
                if (mem_a !== 32'(32'h100 + k - 1) || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL ic_read_addr k=%0d: mem_a=%h wr=%b, required %h wr=0",
                             k, mem_a, mem_wr, 32'(32'h100 + k - 1));
                end
            end
            checks++;
            if (ic_done !== (k == 6)) begin
                errors++;
                $display("FAIL ic_read_done k=%0d: ic_done=%b, required %b", k, ic_done, (k == 6));
            end
            if (ic_done === 1'b1) begin
                ndone++;
                ic_valid = 1'b0;
                checks++;
                if (q_ic.size() == 0) begin
                    errors++;
                    $display("FAIL ic_read_data: unexpected ic_done, data=%h", ic_data);
                end else begin
                    exp = q_ic.pop_front();
                    if (ic_data !== exp) begin
                        errors++;
                        $display("FAIL ic_read_data: ic_data=%h, required %h", ic_data, exp);
                    end
                end
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL ic_read_pulses: %0d done pulses, required 1", ndone);
        end
    endtask

    task automatic test_store_half();
        wr_t e;
        cyc();
        lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h200; lsb_len = 3'd2; lsb_wdata = 32'hAABB_CCDD;
        q_wr.push_back('{a: 32'h200, d: 8'hDD});
        q_wr.push_back('{a: 32'h201, d: 8'hCC});
        smp();
        for (int k = 1; k <= 5; k++) begin
            cyc(); smp();
            checks++;
            if (mem_wr !== (k <= 2)) begin
                errors++;
                $display("FAIL store_half_wr k=%0d: mem_wr=%b, required %b", k, mem_wr, (k <= 2));
            end
            if (mem_wr === 1'b1) begin
                checks++;
                if (q_wr.size() == 0) begin
                    errors++;
                    $display("FAIL store_half_byte: unexpected write a=%h d=%h", mem_a, mem_dout);
                end else begin
                    e = q_wr.pop_front();
                    if (mem_a !== e.a || mem_dout !== e.d) begin
                        errors++;
                        $display("FAIL store_half_byte: a=%h d=%h, required a=%h d=%h", mem_a, mem_dout, e.a, e.d);
                    end
                end
            end
            checks++;
            if (lsb_done !== (k == 3)) begin
                errors++;
                $display("FAIL store_half_done k=%0d: lsb_done=%b, required %b", k, lsb_done, (k == 3));
            end
            if (lsb_done === 1'b1) lsb_valid = 1'b0;
        end
        checks++;
        if (q_wr.size() != 0) begin
            errors++;
            $display("FAIL store_half_missing: %0d writes not seen, required 0", q_wr.size());
            q_wr.delete();
        end
    endtask

    task automatic test_simultaneous();
        int n_ic = 0;
        ev_t e;
        cyc(); rst = 1'b1; smp();
        cyc(); rst = 1'b0;
        ic_valid = 1'b1; ic_addr = 32'h400;
        lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h300; lsb_len = 3'd1;
        q_ev.push_back('{is_lsb: 1'b0, cyc: 6,  data: 32'h4433_2211});
        q_ev.push_back('{is_lsb: 1'b1, cyc: 9,  data: 32'h0000_007F});
        q_ev.push_back('{is_lsb: 1'b0, cyc: 15, data: 32'h4433_2211});
        smp();
        for (int k = 1; k <= 20; k++) begin
            cyc(); smp();
            if (ic_done === 1'b1) begin
                checks++;
                if (q_ev.size() == 0) begin
                    errors++;
                    $display("FAIL simul_ic: unexpected ic_done at cycle %0d", k);
                end else begin
                    e = q_ev.pop_front();
                    if (e.is_lsb || e.cyc != k || ic_data !== e.data) begin
                        errors++;
                        $display("FAIL simul_ic: ic_done at cycle %0d data=%h, required %s at cycle %0d data=%h",
                                 k, ic_data, e.is_lsb ? "lsb" : "ic", e.cyc, e.data);
                    end
                end
                n_ic++;
                if (n_ic == 2) ic_valid = 1'b0;
            end
            if (lsb_done === 1'b1) begin
                checks++;
                if (q_ev.size() == 0) begin
                    errors++;
                    $display("FAIL simul_lsb: unexpected lsb_done at cycle %0d", k);
                end else begin
                    e = q_ev.pop_front();
                    if (!e.is_lsb || e.cyc != k || lsb_rdata !== e.data) begin
                        errors++;
                        $display("FAIL simul_lsb: lsb_done at cycle %0d data=%h, required %s at cycle %0d data=%h",
                                 k, lsb_rdata, e.is_lsb ? "lsb" : "ic", e.cyc, e.data);
                    end
                end
                lsb_valid = 1'b0;
            end
        end
        checks++;
        if (q_ev.size() != 0) begin
            errors++;
            $display("FAIL simul_timeout: %0d completions not seen, required 0", q_ev.size());
            q_ev.delete();
        end
    endtask

    task automatic test_io_stall();
        int nwr = 0;
        wr_t e;
        cyc();
        lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h3_0000; lsb_len = 3'd1; lsb_wdata = 32'h1234_5641;
        q_wr.push_back('{a: 32'h3_0000, d: 8'h41});
        smp();
        for (int k = 1; k <= 6; k++) begin
            cyc(); io_buffer_full = (k <= 3); smp();
            checks++;
            if (mem_wr !== (k == 4)) begin
                errors++;
                $display("FAIL io_stall_wr k=%0d: mem_wr=%b, required %b", k, mem_wr, (k == 4));
            end
            if (k <= 3) begin
                checks++;
                if (mem_a !== 32'h0) begin
                    errors++;
                    $display("FAIL io_stall_addr k=%0d: mem_a=%h, required 0", k, mem_a);
                end
            end
            if (mem_wr === 1'b1) begin
                nwr++;
                checks++;
                if (q_wr.size() == 0) begin
                    errors++;
                    $display("FAIL io_stall_byte: unexpected write a=%h d=%h", mem_a, mem_dout);
                end else begin
                    e = q_wr.pop_front();
                    if (mem_a !== e.a || mem_dout !== e.d) begin
                        errors++;
                        $display("FAIL io_stall_byte: a=%h d=%h, required a=%h d=%h", mem_a, mem_dout, e.a, e.d);
                    end
                end
            end
            checks++;
            if (lsb_done !== (k == 5)) begin
                errors++;
                $display("FAIL io_stall_done k=%0d: lsb_done=%b, required %b", k, lsb_done, (k == 5));
            end
            if (lsb_done === 1'b1) lsb_valid = 1'b0;
        end
        io_buffer_full = 1'b0;
        checks++;
        if (nwr != 1) begin
            errors++;
            $display("FAIL io_stall_count: %0d writes, required 1", nwr);
            q_wr.delete();
        end
    endtask

    task automatic test_rollback();
        wr_t e;
        cyc(); ic_valid = 1'b1; ic_addr = 32'h100; smp();
        for (int k = 1; k <= 9; k++) begin
            cyc();
            rollback = (k == 3);
            if (k == 3) ic_valid = 1'b0;
            smp();
            if (k == 3 || k == 4) begin
                checks++;
                if (mem_a !== ((k == 3) ? 32'h102 : 32'h0) || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL rollback_rd_addr k=%0d: mem_a=%h wr=%b, required %h wr=0",
                             k, mem_a, mem_wr, (k == 3) ? 32'h102 : 32'h0);
                end
            end
            checks++;
            if (ic_done !== 1'b0) begin
                errors++;
                $display("FAIL rollback_rd_done k=%0d: ic_done=%b, required 0", k, ic_done);
            end
        end
        rollback = 1'b0;
        cyc();
        lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h500; lsb_len = 3'd4; lsb_wdata = 32'h8765_4321;
        q_wr.push_back('{a: 32'h500, d: 8'h21});
        q_wr.push_back('{a: 32'h501, d: 8'h43});
        q_wr.push_back('{a: 32'h502, d: 8'h65});
        q_wr.push_back('{a: 32'h503, d: 8'h87});
        smp();
        for (int k = 1; k <= 7; k++) begin
            cyc(); rollback = (k == 2); smp();
            checks++;
            if (mem_wr !== (k <= 4)) begin
                errors++;
                $display("FAIL rollback_wr k=%0d: mem_wr=%b, required %b", k, mem_wr, (k <= 4));
            end
            if (mem_wr === 1'b1 && q_wr.size() != 0) begin
                e = q_wr.pop_front();
                checks++;
                if (mem_a !== e.a || mem_dout !== e.d) begin
                    errors++;
                    $display("FAIL rollback_wr_byte: a=%h d=%h, required a=%h d=%h", mem_a, mem_dout, e.a, e.d);
                end
            end
            checks++;
            if (lsb_done !== (k == 5)) begin
                errors++;
                $display("FAIL rollback_wr_done k=%0d: lsb_done=%b, required %b", k, lsb_done, (k == 5));
            end
            if (lsb_done === 1'b1) lsb_valid = 1'b0;
        end
        rollback = 1'b0;
        checks++;
        if (q_wr.size() != 0) begin
            errors++;
            $display("FAIL rollback_wr_missing: %0d writes not seen, required 0", q_wr.size());
            q_wr.delete();
        end
    endtask

    task automatic test_rdy_pause();
        logic [31:0] exp_a [1:6];
        logic [31:0] exp;
        wr_t e;
        exp_a = '{32'h600, 32'h601, 32'h602, 32'h602, 32'h602, 32'h603};
        cyc(); ic_valid = 1'b1; ic_addr = 32'h600; q_ic.push_back(32'hEFBE_ADDE); smp();
        for (int k = 1; k <= 10; k++) begin
            cyc(); rdy = !(k == 3 || k == 4); smp();
            if (k <= 6) begin
                checks++;
                if (mem_a !== exp_a[k] || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL rdy_rd_addr k=%0d: mem_a=%h wr=%b, required %h wr=0", k, mem_a, mem_wr, exp_a[k]);
                end
            end
            checks++;
            if (ic_done !== (k == 8)) begin
                errors++;
                $display("FAIL rdy_rd_done k=%0d: ic_done=%b, required %b", k, ic_done, (k == 8));
            end
            if (ic_done === 1'b1 && q_ic.size() != 0) begin
                exp = q_ic.pop_front();
                ic_valid = 1'b0;
                checks++;
                if (ic_data !== exp) begin
                    errors++;
                    $display("FAIL rdy_rd_data: ic_data=%h, required %h", ic_data, exp);
                end
            end
        end
        rdy = 1'b1;
        ic_valid = 1'b0;
        q_ic.delete();
        cyc();
        lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h700; lsb_len = 3'd4; lsb_wdata = 32'h0A0B_0C0D;
        q_wr.push_back('{a: 32'h700, d: 8'h0D});
        q_wr.push_back('{a: 32'h701, d: 8'h0C});
        q_wr.push_back('{a: 32'h702, d: 8'h0B});
        q_wr.push_back('{a: 32'h703, d: 8'h0A});
        smp();
        for (int k = 1; k <= 7; k++) begin
            cyc(); rdy = (k != 2); smp();
            checks++;
            if (mem_wr !== (k != 2 && k <= 5)) begin
                errors++;
                $display("FAIL rdy_wr k=%0d: mem_wr=%b, required %b", k, mem_wr, (k != 2 && k <= 5));
            end
            if (k == 2) begin
                checks++;
                if (mem_a !== 32'h701) begin
                    errors++;
                    $display("FAIL rdy_wr_hold: mem_a=%h, required 00000701", mem_a);
                end
            end
            if (mem_wr === 1'b1 && q_wr.size() != 0) begin
                e = q_wr.pop_front();
                checks++;
                if (mem_a !== e.a || mem_dout !== e.d) begin
                    errors++;
                    $display("FAIL rdy_wr_byte: a=%h d=%h, required a=%h d=%h", mem_a, mem_dout, e.a, e.d);
                end
            end
            checks++;
            if (lsb_done !== (k == 6)) begin
                errors++;
                $display("FAIL rdy_wr_done k=%0d: lsb_done=%b, required %b", k, lsb_done, (k == 6));
            end
            if (lsb_done === 1'b1) lsb_valid = 1'b0;
        end
        rdy = 1'b1;
        checks++;
        if (q_wr.size() != 0) begin
            errors++;
            $display("FAIL rdy_wr_missing: %0d writes not seen, required 0", q_wr.size());
            q_wr.delete();
        end
    endtask

    task automatic test_reset_mid();
        cyc(); ic_valid = 1'b1; ic_addr = 32'h100; smp();
        for (int k = 1; k <= 8; k++) begin
            cyc();
            rst = (k == 2);
            if (k == 2) ic_valid = 1'b0;
            smp();
            if (k == 3) begin
                checks++;
                if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_bus: mem_a=%h wr=%b, required 0", mem_a, mem_wr);
                end
            end
            checks++;
            if (ic_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_done k=%0d: ic_done=%b, required 0", k, ic_done);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h300] = 8'h7F;
        ram[32'h400] = 8'h11; ram[32'h401] = 8'h22; ram[32'h402] = 8'h33; ram[32'h403] = 8'h44;
        ram[32'h600] = 8'hDE; ram[32'h601] = 8'hAD; ram[32'h602] = 8'hBE; ram[32'h603] = 8'hEF;
        test_reset();
        test_ic_read();
        test_store_half();
        test_simultaneous();
        test_io_stall();
        test_rollback();
        test_rdy_pause();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM/IO bus between the instruction-cache line-fill requester and the load/store buffer.
- Sequences multi-byte accesses (1/2/4 bytes) as byte-serial transfers, little-endian.
- Arbitrates round-robin between the two requesters and stalls IO writes while the UART buffer is full.
- Aborts speculative reads on rollback; sits between the cache/LSB and the top-level memory pins.

Parameters:
- IO_SEL, 2'b11, value of addr[17:16] that marks an IO address.
- ADDR_W, 32, address width on all ports.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- mem_din  in  8  read data byte; returns the byte addressed in the previous cycle
- mem_dout  out  8  write data byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART transmit buffer full
- ic_valid  in  1  icache read request, held until ic_done
- ic_addr  in  32  icache read address (4 bytes)
- ic_done  out  1  one-cycle completion pulse
- ic_data  out  32  read word, valid while ic_done=1
- lsb_valid  in  1  LSB request, held with its fields until lsb_done
- lsb_wr  in  1  1 = store
- lsb_addr  in  32  byte address
- lsb_wdata  in  32  store data in the low lsb_len bytes
- lsb_len  in  3  byte count: 1, 2 or 4 only
- lsb_done  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, zero-extended, valid while lsb_done=1
- rollback  in  1  pipeline flush

Behaviour:
- Clocking and reset:
  - Synchronous active-high reset on clk.
  - Reset state: IDLE, last_grant=LSB (so icache wins first tie).
  - All outputs reset to 0: mem_a, mem_dout, mem_wr, ic_done, ic_data, lsb_done, lsb_rdata.
  - Reset asserted mid-transfer abandons it, and no done pulse is issued.
- rdy=0: no state, counter or output register changes, except that mem_wr is forced to 0 for that cycle.
- States: IDLE, IC_RD, LSB_RD, LSB_WR. A byte counter cnt (0..4) and a latched copy of the granted request are kept.
- IDLE:
  - A requester whose done pulse is high this cycle is treated as not requesting.
  - If only one requester is valid, it is granted.
  - If both are valid, grant the one not equal to last_grant, then update last_grant.
  - On grant, latch addr/len/wdata and set cnt=0.
  - Outputs in IDLE: mem_wr=0, mem_a=0.
- Reads (IC_RD, LSB_RD), with N=4 for icache and N=lsb_len for LSB:
  - The grant is sampled at cycle t.
  - In cycles t+1..t+N, mem_a = addr+cnt.
  - In cycles t+2..t+N+1, mem_din is written into byte (cnt-1) of the result (bits 8i+7:8i).
  - done=1 and data are valid at cycle t+N+2; the FSM is in IDLE in that cycle.
- Writes (LSB_WR):
  - In cycles t+1..t+N: mem_wr=1, mem_a=addr+cnt, mem_dout=wdata byte cnt.
  - lsb_done=1 at cycle t+N+1.
- IO stall:
  - Applies in LSB_WR when addr[17:16]==IO_SEL and io_buffer_full=1.
  - mem_wr=0, mem_a=0, and cnt is held; the byte is re-issued on the first cycle io_buffer_full=0.
  - Reads are not stalled.
- Rollback:
  - In IC_RD or LSB_RD: go to IDLE next cycle, no done pulse, partial data discarded.
  - In LSB_WR it is ignored (stores are committed); the write completes with lsb_done.
  - In IDLE: no grant is made that cycle.
- Address arithmetic: 32-bit wrapping add; no alignment checks.
- Throughput: back-to-back grants are possible. The earliest next grant is the done cycle +1 for the same requester, or the done cycle itself for the other requester.

Test Plan:
- Icache read:
  - Stimulus: ic_valid, ic_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00.
  - Required: mem_a=0x100..0x103 on consecutive cycles; ic_done at t+6 with ic_data=0x00000513; a single pulse.
- LSB halfword store:
  - Stimulus: lsb_wr=1, addr=0x200, len=2, wdata=0xAABBCCDD.
  - Required: (0x200, 0xDD, wr=1) then (0x201, 0xCC, wr=1); lsb_done at t+3; mem_wr=0 afterwards.
- Simultaneous requests after reset:
  - Stimulus: both valid.
  - Required: icache served first, then LSB (1-byte load, 0x7F at 0x300 → lsb_rdata=0x0000007F), then icache again if still requesting.
- IO stall:
  - Stimulus: 1-byte store to 0x30000 with data 0x41, io_buffer_full high for 3 cycles.
  - Required: mem_wr=0 for those 3 cycles, then a single write (0x30000, 0x41); lsb_done one cycle later.
- Rollback:
  - Stimulus: rollback during the third byte of an icache read.
  - Required: FSM in IDLE next cycle, no ic_done. The same pulse during a 4-byte store has no effect: all 4 bytes are written and lsb_done is asserted.
- rdy pause:
  - Stimulus: rdy=0 for 2 cycles mid 4-byte read.
  - Required: mem_a is held, mem_wr=0, and completion is delayed by exactly 2 cycles with correct data.
